// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file sweep controller and its datapath.
//   - default WIDTH/DEPTH constants
//   - clog2 helper (minimum result of 1, so a 1-entry file still has a 1-bit address)
//   - controller state encodings, kept here so controller and datapath agree
package regfile_pkg;

    localparam int REGFILE_WIDTH_DEF = 8;
    localparam int REGFILE_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        SWEEP_WAIT = 2'd0,
        SWEEP_INIT = 2'd1,
        SWEEP_STEP = 2'd2,
        SWEEP_CMP  = 2'd3
    } sweep_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/regfile_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one registered
// read port, and a synchronous master clear of every entry.
// Ports:
//   clk      clock
//   Mrst     synchronous active-high clear of all entries and rd_data
//   we       write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address (out-of-range reads return 0)
//   rd_data  registered read data; same-address read/write returns old data
module regfile_mem
    import regfile_pkg::*;
#(
    parameter int WIDTH = REGFILE_WIDTH_DEF,
    parameter int DEPTH = REGFILE_DEPTH_DEF,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             Mrst,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (Mrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads sample mem before this edge's write lands, giving old-data behaviour.
    always_ff @(posedge clk) begin
        if (Mrst) begin
            rd_data <= '0;
        end else if (32'(rd_addr) < 32'(DEPTH)) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/regfile_sweep_datapath.sv
// Datapath for the register-file sweep controller. Each controller step
// writes data_in at a walking address; compare flags that the last entry of
// the sweep has been written.
// Ports:
//   clk       clock
//   Mrst      synchronous active-high master reset (clears file too)
//   rst       controller clear: restarts the sweep, file contents kept
//   enable    controller step request
//   activo    controller busy; enable is ignored while low
//   data_in   value written on a step
//   rd_addr   read address
//   rd_data   registered read data
//   wr_addr   current write pointer
//   compare   last sweep entry has been written
//   checksum  running XOR of written data
// Build option: define REGFILE_CHECKSUM_EN to enable the checksum
// accumulator; otherwise checksum is tied to 0.
module regfile_sweep_datapath
    import regfile_pkg::*;
#(
    parameter int WIDTH     = REGFILE_WIDTH_DEF,
    parameter int DEPTH     = REGFILE_DEPTH_DEF,
    parameter int SWEEP_LEN = 16,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             Mrst,
    input  logic             rst,
    input  logic             enable,
    input  logic             activo,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW-1:0]    wr_addr,
    output logic             compare,
    output logic [WIDTH-1:0] checksum
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(SWEEP_LEN - 1);

    logic step;
    logic at_last;

    assign step    = enable & activo & ~rst & ~Mrst;
    assign at_last = (wr_addr == LAST_ADDR);

    regfile_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .Mrst    (Mrst),
        .we      (step),
        .wr_addr (wr_addr),
        .wr_data (data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (Mrst || rst) begin
            wr_addr <= '0;
            compare <= 1'b0;
        end else if (step) begin
            wr_addr <= at_last ? '0 : wr_addr + AW'(1);
            compare <= at_last;
        end
    end

`ifdef REGFILE_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (Mrst || rst) begin
            checksum <= '0;
        end else if (step) begin
            checksum <= checksum ^ data_in;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_sweep_datapath.sv
module tb_regfile_sweep_datapath;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int SL = 16;

    logic         clk = 1'b0;
    logic         Mrst = 1'b0, rst = 1'b0, enable = 1'b0, activo = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [3:0]   rd_addr = '0;
    logic [W-1:0] rd_data;
    logic [3:0]   wr_addr;
    logic         compare;
    logic [W-1:0] checksum;

    regfile_sweep_datapath #(.WIDTH(W), .DEPTH(D), .SWEEP_LEN(SL)) dut (
        .clk      (clk),
        .Mrst     (Mrst),
        .rst      (rst),
        .enable   (enable),
        .activo   (activo),
        .data_in  (data_in),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_addr  (wr_addr),
        .compare  (compare),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] rd;
        logic [3:0]   wa;
        logic         cmp;
        logic [W-1:0] ck;
        int           ph;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: contents, pointer as a plain integer, sweep-done flag.
    int           m_mem [D];
    int           m_ptr = 0;
    bit           m_cmp = 0;
    int           m_ck  = 0;
    int           phase = 0;

    task automatic cyc(input bit mr, input bit r, input bit en, input bit act,
                       input int din, input int ra);
        exp_t e;
        int   rd_exp;
        @(negedge clk);
        Mrst = mr; rst = r; enable = en; activo = act;
        data_in = W'(din); rd_addr = 4'(ra);
        if (mr) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_ptr = 0; m_cmp = 0; m_ck = 0; rd_exp = 0;
        end else begin
            rd_exp = (ra < D) ? m_mem[ra] : 0;
            if (r) begin
                m_ptr = 0; m_cmp = 0; m_ck = 0;
            end else if (en && act) begin
                m_mem[m_ptr] = din;
                m_cmp = (m_ptr == SL - 1);
                m_ptr = (m_ptr + 1) % SL;
`ifdef REGFILE_CHECKSUM_EN
                m_ck = m_ck ^ din;
`endif
            end
        end
        e.rd = W'(rd_exp); e.wa = 4'(m_ptr); e.cmp = m_cmp; e.ck = W'(m_ck); e.ph = phase;
        sb.push_back(e);
    endtask

    task automatic idle(input int ra);
        cyc(0, 0, 0, 1, $urandom_range(0, 255), ra);
    endtask

    task automatic stepw(input int din, input int ra);
        cyc(0, 0, 1, 1, din, ra);
    endtask

    // Monitor: registered outputs are valid every cycle, checked 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (rd_data !== e.rd) begin
                    n_err++;
                    $display("FAIL rd_data phase=%0d got=%h want=%h", e.ph, rd_data, e.rd);
                end
                n_vec++;
                if (wr_addr !== e.wa) begin
                    n_err++;
                    $display("FAIL wr_addr phase=%0d got=%0d want=%0d", e.ph, wr_addr, e.wa);
                end
                n_vec++;
                if (compare !== e.cmp) begin
                    n_err++;
                    $display("FAIL compare phase=%0d got=%b want=%b", e.ph, compare, e.cmp);
                end
                n_vec++;
                if (checksum !== e.ck) begin
                    n_err++;
                    $display("FAIL checksum phase=%0d got=%h want=%h", e.ph, checksum, e.ck);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        // Phase 1: load 0xFF everywhere, then Mrst for 2 cycles clears it all.
        phase = 1;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) stepw(8'hFF, i);
        cyc(1, 1, 1, 1, 8'hAA, 0);
        cyc(1, 0, 1, 1, 8'hAA, 1);
        for (int i = 0; i < 16; i++) idle(i);
        idle(0);

        // Phase 2: full sweep with 0x10+i, compare only after step 16.
        phase = 2;
        for (int i = 0; i < 16; i++) stepw(8'h10 + i, $urandom_range(0, 15));
        for (int i = 0; i < 16; i++) idle(i);
        idle(0);

        // Phase 3: compare holds; next step clears it and overwrites entry 0 (read sees old).
        phase = 3;
        for (int i = 0; i < 5; i++) idle($urandom_range(0, 15));
        stepw(8'h5A, 0);
        idle(0);
        idle(0);

        // Phase 4: enable without activo does nothing; rst beats enable.
        phase = 4;
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, $urandom_range(0, 255), i);
        for (int i = 0; i < 3; i++) idle(i);
        cyc(0, 1, 1, 1, 8'hEE, 1);
        for (int i = 0; i < 3; i++) idle(i);

        // Phase 5: mid-sweep rst keeps contents; same-address read/write returns old data.
        phase = 5;
        for (int i = 0; i < 7; i++) stepw(8'h60 + i, i);
        cyc(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) idle(i);
        for (int i = 0; i < 3; i++) stepw(8'h70 + i, 7);
        stepw(8'h99, 3);
        idle(3);
        idle(3);

        // Phase 6: checksum 0x0F ^ 0xF0 ^ 0x3C, then cleared by rst.
        phase = 6;
        cyc(0, 1, 0, 1, 0, 0);
        stepw(8'h0F, 0);
        stepw(8'hF0, 1);
        stepw(8'h3C, 2);
        idle(0);
        cyc(0, 1, 0, 1, 0, 0);
        idle(0);

        // Phase 7: randomized traffic with occasional resets.
        phase = 7;
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
                $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                $urandom_range(0, 255), $urandom_range(0, 15));
        end

        repeat (4) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
